// File: rtl/asp_pkg.sv
// asp_pkg: declarations shared by the ASP operation scheduler files.
//   sched_state_t : scheduler FSM state (IDLE / ISSUE / BUSY)
//   OP_*          : datapath opcodes for the default channel wiring
//   CH_*          : request channel indices for the default wiring
//   age_width()   : width of an age counter for a given AGE_MAX
package asp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_BUSY  = 2'd2
   } sched_state_t;

   localparam int OP_NOP = 0;
   localparam int OP_TXE = 1;
   localparam int OP_RXA = 2;
   localparam int OP_LOG = 3;

   localparam int CH_TXE = 0;
   localparam int CH_RXA = 1;
   localparam int CH_LOG = 2;

   // The counter must hold 0..AGE_MAX. It is kept at least one bit wide so
   // that AGE_MAX=0 (aging disabled) still gives a legal vector.
   function automatic int age_width(input int age_max);
      return (age_max < 1) ? 1 : $clog2(age_max + 1);
   endfunction

endpackage

// File: rtl/asp_prio_pick.sv
// asp_prio_pick: combinational request picker for the operation scheduler.
//   req      in  NUM_REQ  request vector
//   start    in  IDX_W    fixed mode: top-priority channel
//                         round-robin mode: first channel searched
//   aged     in  NUM_REQ  channels whose age counter has reached the limit
//   rr_mode  in  1        0 = fixed priority with aging, 1 = round-robin
//   pick     out NUM_REQ  one-hot pick (all zero when req is zero)
//   pick_idx out IDX_W    index of the picked channel
module asp_prio_pick
   import asp_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   start,
   input  logic [NUM_REQ-1:0] aged,
   input  logic               rr_mode,
   output logic [NUM_REQ-1:0] pick,
   output logic [IDX_W-1:0]   pick_idx
);

   logic [NUM_REQ-1:0] aged_req;
   logic [IDX_W-1:0]   cand;
   logic               found;

   always_comb begin
      aged_req = req & aged;
      pick     = '0;
      pick_idx = '0;
      cand     = '0;
      found    = 1'b0;
      if (rr_mode) begin
         // Ascending search with wrap, beginning at start.
         for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(start) + k) % NUM_REQ);
            if (!found && req[cand]) begin
               found    = 1'b1;
               pick_idx = cand;
            end
         end
      end else if (|aged_req) begin
         // Starved channels beat everyone; lowest index among them.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && aged_req[i]) begin
               found    = 1'b1;
               pick_idx = IDX_W'(i);
            end
         end
      end else if (req[start]) begin
         found    = 1'b1;
         pick_idx = start;
      end else begin
         // The top channel is idle: the rest go in ascending index order.
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!found && req[i]) begin
               found    = 1'b1;
               pick_idx = IDX_W'(i);
            end
         end
      end
      if (found) begin
         pick[pick_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/asp_op_scheduler.sv
// asp_op_scheduler: issues one datapath opcode at a time from NUM_REQ
// level-sensitive request lines, then waits for completion.
//   clk, reset    in   clock; synchronous active-high reset
//   req_in        in   level requests (bit0 TXE, bit1 RXA, bit2 LOG)
//   rr_mode_in    in   0 = fixed priority with aging, 1 = round-robin
//   op_ready_in   in   datapath accepts the offered opcode
//   op_done_in    in   datapath finished the accepted operation
//   op_valid_out  out  opcode offered (ISSUE)
//   opcode_out    out  granted index+1 in ISSUE/BUSY, 0 (NOP) in IDLE
//   grant_out     out  one-hot grant in ISSUE/BUSY
//   busy_out      out  high in ISSUE and BUSY
//   state_out     out  current scheduler state, for debug
//
// Handshake: the opcode transfers on the edge where op_valid_out and
// op_ready_in are both high; op_valid_out stays high with a stable opcode
// until then. op_done_in counts only in BUSY and op_ready_in only in ISSUE.
// Requests and mode are sampled only in IDLE.
module asp_op_scheduler
   import asp_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int OP_W     = $clog2(NUM_REQ + 1),
   parameter int PRIO_TOP = CH_RXA,
   parameter int AGE_MAX  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_REQ-1:0] req_in,
   input  logic               rr_mode_in,
   input  logic               op_ready_in,
   input  logic               op_done_in,
   output logic               op_valid_out,
   output logic [OP_W-1:0]    opcode_out,
   output logic [NUM_REQ-1:0] grant_out,
   output logic               busy_out,
   output sched_state_t       state_out
);

   localparam int               IDX_W    = $clog2(NUM_REQ);
   localparam int               AGE_W    = age_width(AGE_MAX);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
   localparam logic [IDX_W-1:0] TOP_IDX  = IDX_W'(PRIO_TOP);
   localparam logic [AGE_W-1:0] AGE_SAT  = AGE_W'(AGE_MAX);

   sched_state_t       state_q;
   sched_state_t       state_d;
   logic [NUM_REQ-1:0] grant_q;
   logic [IDX_W-1:0]   grant_idx_q;
   logic [IDX_W-1:0]   last_grant_q;
   logic [AGE_W-1:0]   age_q [NUM_REQ];

   logic [NUM_REQ-1:0] aged;
   logic [IDX_W-1:0]   start;
   logic [NUM_REQ-1:0] pick;
   logic [IDX_W-1:0]   pick_idx;
   logic               take;

   // A grant is taken on every IDLE cycle with any request pending.
   assign take = (state_q == ST_IDLE) && (|req_in);

   always_comb begin
      start = TOP_IDX;
      if (rr_mode_in) begin
         start = (last_grant_q == LAST_IDX) ? '0 : last_grant_q + IDX_W'(1);
      end
   end

   always_comb begin
      aged = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if ((AGE_MAX > 0) && (age_q[i] == AGE_SAT)) begin
            aged[i] = 1'b1;
         end
      end
   end

   asp_prio_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req      (req_in),
      .start    (start),
      .aged     (aged),
      .rr_mode  (rr_mode_in),
      .pick     (pick),
      .pick_idx (pick_idx)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (take)        state_d = ST_ISSUE;
         ST_ISSUE: if (op_ready_in) state_d = ST_BUSY;
         ST_BUSY:  if (op_done_in)  state_d = ST_IDLE;
         default:                   state_d = ST_IDLE;
      endcase
   end

   // Grant, last_grant and age counters change only when a grant is taken.
   // Ages move only on fixed-mode grants, so they freeze in round-robin.
   always_ff @(posedge clk) begin
      if (reset) begin
         grant_q      <= '0;
         grant_idx_q  <= '0;
         last_grant_q <= LAST_IDX;
         for (int i = 0; i < NUM_REQ; i++) begin
            age_q[i] <= '0;
         end
      end else if (take) begin
         grant_q      <= pick;
         grant_idx_q  <= pick_idx;
         last_grant_q <= pick_idx;
         if (!rr_mode_in) begin
            for (int i = 0; i < NUM_REQ; i++) begin
               if (pick[i] || !req_in[i]) begin
                  age_q[i] <= '0;
               end else if (age_q[i] != AGE_SAT) begin
                  age_q[i] <= age_q[i] + AGE_W'(1);
               end
            end
         end
      end
   end

   // Outputs are decoded from registered state only.
   always_comb begin
      op_valid_out = 1'b0;
      opcode_out   = '0;
      grant_out    = '0;
      busy_out     = 1'b0;
      case (state_q)
         ST_ISSUE: begin
            op_valid_out = 1'b1;
            busy_out     = 1'b1;
            opcode_out   = OP_W'(grant_idx_q) + OP_W'(1);
            grant_out    = grant_q;
         end
         ST_BUSY: begin
            busy_out   = 1'b1;
            opcode_out = OP_W'(grant_idx_q) + OP_W'(1);
            grant_out  = grant_q;
         end
         default: ;
      endcase
   end

   assign state_out = state_q;

endmodule

// File: doc/asp_op_scheduler.md
# asp_op_scheduler

Parametrised operation scheduler for the ASP datapath. It arbitrates among NUM_REQ level-sensitive request lines (transmit, receive, log and future sources) and issues one opcode at a time to the datapath over a valid/ready handshake. It then holds off further issue until the datapath signals completion. Fixed-priority and round-robin modes are selectable at run time, and fixed-priority mode includes age-based starvation protection.

## Interface
- NUM_REQ, 3: number of request channels, 2..15.
- OP_W, $clog2(NUM_REQ+1): opcode width.
- PRIO_TOP, 1: highest-priority channel in fixed mode.
- AGE_MAX, 4: grants a channel may lose while requesting before promotion. 0 disables aging.
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- req_in  in  NUM_REQ  level requests. Default wiring: bit0 TXE (dpp ready), bit1 RXA (nd ready), bit2 LOG (na).
- rr_mode_in  in  1  0 = fixed priority, 1 = round-robin.
- op_ready_in  in  1  datapath accepts the offered opcode.
- op_done_in  in  1  datapath finished the accepted operation.
- op_valid_out  out  1  opcode offered.
- opcode_out  out  OP_W  granted index+1 while valid, else 0 (NOP).
- grant_out  out  NUM_REQ  one-hot grant, held from ISSUE through BUSY.
- busy_out  out  1  high in ISSUE and BUSY.

## Operation
- States:
  - IDLE: arbitrates each cycle. Any req_in bit set → ISSUE.
  - ISSUE: holds op_valid_out. op_ready_in → BUSY.
  - BUSY: waits. op_done_in → IDLE.
- req_in and rr_mode_in are sampled only in IDLE. Request changes during ISSUE/BUSY never cancel or alter the grant.
- op_done_in outside BUSY is ignored. op_ready_in outside ISSUE is ignored.
- Fixed mode order: PRIO_TOP first, then the remaining channels in ascending index. Default order is RXA, TXE, LOG.
- Aging, fixed mode only:
  - Each channel has a counter, width $clog2(AGE_MAX+1).
  - On each grant to another channel, the counter increments (saturating) if that channel's request is set.
  - The counter clears when its channel is granted or its request is low at a grant.
  - A channel whose counter equals AGE_MAX outranks all non-aged channels. Among aged channels, the lowest index wins.
- Round-robin mode:
  - The search starts at last_grant+1 (mod NUM_REQ) and proceeds ascending with wrap.
  - last_grant updates on every grant in both modes.
  - Age counters hold their value while in round-robin mode.
- Reset values:
  - State IDLE.
  - All outputs 0.
  - last_grant = NUM_REQ-1, so the first round-robin search starts at 0.
  - Age counters 0.
- Reset mid-operation aborts immediately. No opcode is re-offered after reset.

## Timing
- The grant is registered. A request present in IDLE at edge k gives op_valid_out=1 with opcode/grant after edge k; this is 1-cycle latency.
- op_valid_out stays high with a stable opcode until the edge where op_ready_in=1. op_valid_out falls after that edge.
- op_done_in in BUSY at edge m → IDLE after m, then a new ISSUE after m+1 if requests are pending.
- The minimum issue period is 3 cycles, with op_ready_in and op_done_in each asserted on the first possible cycle.
- opcode_out and grant_out remain valid through BUSY. opcode_out returns to 0 in IDLE.
- Simultaneous requests are resolved purely by the mode rules; no cycle is ever wasted when any request is pending in IDLE.

## Structure
- Shared package asp_pkg holds:
  - the scheduler state enum (IDLE/ISSUE/BUSY);
  - opcode constants OP_NOP=0, OP_TXE=1, OP_RXA=2, OP_LOG=3;
  - channel index constants CH_TXE=0, CH_RXA=1, CH_LOG=2.
- One sub-module, asp_prio_pick, is combinational. Inputs: request vector, start index, aged mask, mode. Output: one-hot pick plus its index.
- The FSM, age counters and last_grant register stay in the top module.

## Test plan
- Fixed mode, req_in=3'b111 held, ready/done immediate → opcodes 2,2,2…; with AGE_MAX=4, the 5th grant is promoted to TXE (1).
- Round-robin mode, req_in=3'b111 after reset → opcodes 1,2,3,1,2,3, each 3 cycles apart.
- req_in=3'b100 for 1 cycle, op_ready_in held low for 5 cycles → op_valid_out high for 5 cycles with opcode 3; busy_out stays high until op_done_in.
- In BUSY, toggle req_in and pulse op_ready_in → grant_out unchanged; no new issue until op_done_in.
- reset asserted during BUSY → the next cycle shows all outputs 0, state IDLE, and round-robin restarting at channel 0.
- NUM_REQ=5, OP_W=3, fixed mode, req_in=5'b10001 → opcode 1; after done, opcode 1 again until aging promotes channel 4 (opcode 5) on the AGE_MAX+1th grant.
